// File: rtl/rank_filter_pipe.sv
// rank_filter_pipe: pipelined 3x3-window rank-order filter with valid/ready on both sides.
// Optional statistics outputs (o_win_cnt, o_stall) are enabled by defining RANK_FILTER_PIPE_STATS_EN.
module rank_filter_pipe #(
  parameter int DATA_W      = 8,
  parameter int SIGNED      = 0,
  parameter int PIPE_STAGES = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [9*DATA_W-1:0] i_data,
  input  logic [3:0]          i_rank,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [DATA_W-1:0]   o_data,
  output logic [3:0]          o_rank
`ifdef RANK_FILTER_PIPE_STATS_EN
  ,
  output logic [31:0]         o_win_cnt,
  output logic                o_stall
`endif
);
  localparam int P      = PIPE_STAGES;
  localparam int LAYERS = 9;
  typedef logic [8:0][DATA_W-1:0] win_t;
  // sd[0] is the capture register; sd[s] holds the window after comparator group s-1
  win_t       sd [P];
  logic [3:0] sr [P];
  logic       sv [P];
  win_t       nx [P];
  logic       adv;
  function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
  endfunction
  // one odd-even transposition layer: even layers compare (0,1),(2,3)..., odd layers (1,2),(3,4)...
  function automatic win_t layer(input win_t a, input int l);
    win_t b;
    b = a;
    for (int i = l % 2; i < 8; i += 2)
      if (gt(a[i], a[i+1])) begin
        b[i]   = a[i+1];
        b[i+1] = a[i];
      end
    return b;
  endfunction
  // a single global enable: every stage shifts or every stage holds
  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;
  // nine transposition layers fully sort nine samples; layers are spread evenly over the stages
  always_comb begin
    for (int g = 0; g < P; g++) begin
      nx[g] = sd[g];
      for (int l = g * LAYERS / P; l < (g + 1) * LAYERS / P; l++) nx[g] = layer(nx[g], l);
    end
  end
  // pipeline registers; the rank travels with its window and picks the sorted sample at the end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < P; s++) begin
        sd[s] <= '0;
        sr[s] <= '0;
        sv[s] <= 1'b0;
      end
      o_valid <= 1'b0;
      o_data  <= '0;
      o_rank  <= '0;
    end else if (adv) begin
      sd[0] <= i_data;
      sr[0] <= (i_rank > 4'd8) ? 4'd8 : i_rank;
      sv[0] <= i_valid;
      for (int s = 1; s < P; s++) begin
        sd[s] <= nx[s-1];
        sr[s] <= sr[s-1];
        sv[s] <= sv[s-1];
      end
      o_valid <= sv[P-1];
      o_data  <= nx[P-1][sr[P-1]];
      o_rank  <= sr[P-1];
    end
  end
`ifdef RANK_FILTER_PIPE_STATS_EN
  // count completed output transfers and flag cycles where a valid result was held back
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_win_cnt <= '0;
      o_stall   <= 1'b0;
    end else begin
      o_win_cnt <= o_win_cnt + 32'(o_valid && i_ready);
      o_stall   <= o_valid && !i_ready;
    end
  end
`endif
endmodule

// File: tb/tb_rank_filter_pipe.sv
// tb_rank_filter_pipe: directed table-driven bench for rank_filter_pipe (unsigned and signed instances).
module tb_rank_filter_pipe;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic [71:0] data;
  logic [3:0]  rank;
  logic        rdy0, v0, rdy1, v1;
  logic [7:0]  d0, d1;
  logic [3:0]  r0, r1;
`ifdef RANK_FILTER_PIPE_STATS_EN
  logic [31:0] cnt0, cnt1;
  logic        st0, st1;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rank_filter_pipe #(.DATA_W(8), .SIGNED(0), .PIPE_STAGES(3)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(rdy0), .i_data(data), .i_rank(rank),
    .o_valid(v0), .i_ready(out_ready), .o_data(d0), .o_rank(r0)
`ifdef RANK_FILTER_PIPE_STATS_EN
    , .o_win_cnt(cnt0), .o_stall(st0)
`endif
  );
  rank_filter_pipe #(.DATA_W(8), .SIGNED(1), .PIPE_STAGES(3)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(rdy1), .i_data(data), .i_rank(rank),
    .o_valid(v1), .i_ready(out_ready), .o_data(d1), .o_rank(r1)
`ifdef RANK_FILTER_PIPE_STATS_EN
    , .o_win_cnt(cnt1), .o_stall(st1)
`endif
  );

  typedef struct {
    logic [71:0] win;
    logic [3:0]  rk;
    logic [7:0]  eu;
    logic [7:0]  es;
    logic [3:0]  er;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] mk(input int v [9]);
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = v[k][7:0];
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a[9];
    logic [71:0] wa, wb, wc, wd, wz;
    logic [71:0] bw[6];
    logic [7:0]  be[6];
    int n, sent, rcv, stalls, ostall, last;
    logic prev;
    a = '{9, 1, 8, 2, 7, 3, 6, 4, 5};                        wa = mk(a);
    a = '{'h80, 'h7F, 0, 'hFF, 1, 'h80, 'h7F, 0, 0};         wb = mk(a);
    a = '{'hAA, 'hAA, 'hAA, 'hAA, 'hAA, 'hAA, 'hAA, 'hAA, 'hAA}; wc = mk(a);
    a = '{3, 3, 200, 0, 255, 17, 128, 64, 3};                wd = mk(a);
    a = '{0, 1, 2, 3, 4, 5, 6, 7, 8};                        wz = mk(a);
    for (int k = 0; k < 9; k++) tv.push_back('{wa, 4'(k), 8'(k + 1), 8'(k + 1), 4'(k)});
    tv.push_back('{wa, 4'd12, 8'd9, 8'd9, 4'd8});
    tv.push_back('{wb, 4'd0, 8'h00, 8'h80, 4'd0});
    tv.push_back('{wb, 4'd2, 8'h00, 8'hFF, 4'd2});
    tv.push_back('{wb, 4'd4, 8'h7F, 8'h00, 4'd4});
    tv.push_back('{wb, 4'd8, 8'hFF, 8'h7F, 4'd8});
    tv.push_back('{wc, 4'd0, 8'hAA, 8'hAA, 4'd0});
    tv.push_back('{wc, 4'd4, 8'hAA, 8'hAA, 4'd4});
    tv.push_back('{wc, 4'd8, 8'hAA, 8'hAA, 4'd8});
    tv.push_back('{wc, 4'd15, 8'hAA, 8'hAA, 4'd8});
    tv.push_back('{wd, 4'd0, 8'h00, 8'h80, 4'd0});
    tv.push_back('{wd, 4'd1, 8'h03, 8'hC8, 4'd1});
    tv.push_back('{wd, 4'd4, 8'h11, 8'h03, 4'd4});
    tv.push_back('{wd, 4'd7, 8'hC8, 8'h11, 4'd7});
    for (int i = 0; i < 6; i++) begin
      int b;
      b = i * 20 + 1;
      a = '{b + 8, b, b + 7, b + 1, b + 6, b + 2, b + 5, b + 3, b + 4};
      bw[i] = mk(a);
      be[i] = 8'(b + 4);
    end

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; data = '0; rank = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(v0), 0);
    chk("rst_data", 32'(d0), 0);
    chk("rst_rank", 32'(r0), 0);
    chk("rst_ready", 32'(rdy0), 1);
    rst_n = 1'b1;

    n = tv.size();
    for (int c = 0; c < n + 4; c++) begin
      @(posedge clk);
      #1;
      in_valid = c < n;
      if (c < n) begin
        data = tv[c].win;
        rank = tv[c].rk;
      end
      #1;
      if (c >= 4) begin
        chk("tbl_valid_u", 32'(v0), 1);
        chk("tbl_data_u", 32'(d0), 32'(tv[c-4].eu));
        chk("tbl_rank_u", 32'(r0), 32'(tv[c-4].er));
        chk("tbl_valid_s", 32'(v1), 1);
        chk("tbl_data_s", 32'(d1), 32'(tv[c-4].es));
        chk("tbl_rank_s", 32'(r1), 32'(tv[c-4].er));
      end else begin
        chk("tbl_latency", 32'(v0), 0);
      end
    end

    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sent = 0; rcv = 0; stalls = 0; ostall = 0; last = -1; prev = 1'b0;
    for (int c = 0; c < 40 && rcv < 6; c++) begin
      @(posedge clk);
      #1;
      in_valid  = sent < 6;
      if (sent < 6) data = bw[sent];
      rank      = 4'd4;
      out_ready = !(c >= 4 && c <= 6);
      #1;
`ifdef RANK_FILTER_PIPE_STATS_EN
      if (st0) ostall++;
`endif
      if (v0 && !out_ready) begin
        stalls++;
        chk("bp_oready", 32'(rdy0), 0);
        if (prev) chk("bp_hold", 32'(d0), 32'(be[rcv]));
      end
      prev = v0 && !out_ready;
      if (v0 && out_ready) begin
        chk("bp_data", 32'(d0), 32'(be[rcv]));
        rcv++;
        last = c;
      end
      if (in_valid && rdy0) sent++;
    end
    chk("bp_count", 32'(rcv), 6);
    chk("bp_last_cycle", 32'(last), 12);
    chk("bp_stalls", 32'(stalls), 3);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
`ifdef RANK_FILTER_PIPE_STATS_EN
    chk("stat_cnt", cnt0, 6);
    chk("stat_stall", 32'(ostall), 3);
    @(posedge clk);
    #1;
    in_valid = 1'b1; data = wa; rank = 4'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    force u0.o_win_cnt = 32'hFFFF_FFFF;
    #1;
    release u0.o_win_cnt;
    for (int c = 0; c < 10 && !v0; c++) begin
      @(posedge clk);
      #1;
    end
    chk("wrap_valid", 32'(v0), 1);
    chk("wrap_pre", cnt0, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    chk("wrap_cnt", cnt0, 0);
`endif

    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      in_valid = c < 4;
      data = wa;
      rank = 4'd4;
    end
    in_valid = 1'b0;
    #1;
    chk("mid_pre_valid", 32'(v0), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", 32'(v0), 0);
    chk("mid_data", 32'(d0), 0);
    chk("mid_rank", 32'(r0), 0);
    chk("mid_ready", 32'(rdy0), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #2;
      chk("mid_no_stale", 32'(v0), 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1; data = wz; rank = 4'd4;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      #1;
      if (c < 4) begin
        chk("post_latency", 32'(v0), 0);
      end else begin
        chk("post_valid", 32'(v0), 1);
        chk("post_data", 32'(d0), 4);
        chk("post_rank", 32'(r0), 4);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rank_filter_pipe.md
Name: rank_filter_pipe

Overview:
- Streaming, pipelined 3x3-window rank-order filter; successor to the combinational median finder.
- Accepts one 9-sample window per beat and fully sorts it with a registered comparator network.
- Outputs the sample at a per-window selectable rank: 0 = min, 4 = median, 8 = max.
- Sits between the window line-buffer and the image writeback stage, with valid/ready on both sides.

Parameters:
- DATA_W, 8, width of each sample in bits.
- SIGNED, 0, compare mode: 0 = unsigned compare, 1 = two's-complement compare.
- PIPE_STAGES, 3, number of register stages through the sort network (1..7).

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream window valid.
- o_ready  output  1  block can accept a window this cycle.
- i_data  input  9*DATA_W  window; sample k at bits [k*DATA_W +: DATA_W].
- i_rank  input  4  requested rank for this window.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_data  output  DATA_W  selected-rank sample.
- o_rank  output  4  rank actually applied, after clamping.

Behaviour:
- Reset is asynchronous. While i_rst_n = 0:
  - all pipeline valid bits clear;
  - o_valid = 0, o_data = 0, o_rank = 0.
  - o_ready = 1 combinationally once in reset, since the pipeline is empty.
- Transfer rules:
  - Input transfer occurs when i_valid && o_ready.
  - Output transfer occurs when o_valid && i_ready.
- Global advance enable: adv = !o_valid || i_ready; o_ready = adv.
  - All stages shift together when adv = 1.
  - All stages hold when adv = 0; data and valid are frozen.
  - Bubbles propagate as invalid slots. They are not compressed.
- Sort network:
  - Any correct 9-input full sorting network, minimum depth preferred (25 comparators / 7 layers is acceptable).
  - Layers are split as evenly as possible into PIPE_STAGES groups, with a register after each group.
  - The rank mux is placed after the last comparator layer and is registered into o_data.
  - The final register counts as one of the PIPE_STAGES stages.
- Latency:
  - A window accepted at edge N appears with o_valid = 1 after edge N+PIPE_STAGES, provided there is no stall.
  - Each stall cycle adds exactly one cycle.
- Throughput: one window per cycle when i_ready is held at 1.
- Rank handling:
  - i_rank is captured with the window and travels alongside it through the pipeline.
  - Values > 8 are clamped to 8 at capture.
  - o_rank reports the clamped value.
- Compare:
  - SIGNED = 0: unsigned magnitude.
  - SIGNED = 1: signed.
  - Ties produce identical values, so no stability requirement applies.
- o_data / o_rank are held stable while o_valid = 1 and i_ready = 0.
- i_data / i_rank are don't-care when i_valid = 0 and are not captured into valid slots.
- Reset mid-stream: all in-flight windows are discarded, nothing is emitted afterward, and the first window accepted after release follows normal latency.

Optional Feature:
- Macro: RANK_FILTER_PIPE_STATS_EN.
- Defined:
  - Adds output port o_win_cnt (32 bits), a count of completed output transfers.
  - Resets to 0 and wraps 0xFFFFFFFF -> 0.
  - Increments on every cycle where o_valid && i_ready.
  - Also adds output o_stall (1 bit), registered, = o_valid && !i_ready in the previous cycle.
- Not defined:
  - Ports and counters are absent.
  - Core datapath behaviour and latency are identical.

Test Plan:
- Median, DATA_W=8, SIGNED=0, PIPE_STAGES=3, i_ready=1: window {9,1,8,2,7,3,6,4,5}, i_rank=4 -> o_data=5, o_rank=4, o_valid exactly 3 cycles after accept.
- Rank sweep: same window, i_rank 0..8 on back-to-back cycles -> o_data 1,2,...,9 on consecutive cycles with no bubbles. i_rank=12 -> o_data=9, o_rank=8.
- Signed and ties:
  - SIGNED=1: window {0x80,0x7F,0x00,0xFF,0x01,0x80,0x7F,0x00,0x00}, rank 0 -> 0x80; rank 4 -> 0x00; rank 8 -> 0x7F.
  - All-equal window 0xAA -> 0xAA for every rank.
- Backpressure:
  - Stream 6 windows with i_ready low for cycles 4-6 -> o_ready low during the stall.
  - o_data held constant while stalled.
  - All 6 results emitted in order with none lost or duplicated.
  - Total cycles = 6 + 3 + 3.
- Reset mid-operation: assert i_rst_n=0 with 3 windows in flight -> o_valid=0 immediately (async); after release, no stale output appears, and a new window {0,..,8} at rank 4 -> 4 after 3 cycles.
- Stats (RANK_FILTER_PIPE_STATS_EN):
  - After the backpressure test, o_win_cnt=6 and o_stall was high for 3 cycles.
  - With the counter preloaded through force to 0xFFFFFFFF, one transfer -> 0.
